// File: rtl/seg7_pkg.sv
// Shared types and segment encoding for the multiplexed 7-segment display driver.
package seg7_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low segment pattern, bit0=a .. bit6=g; non-BCD values blank.
    function automatic seg_t seg_code(input logic [NIB_W-1:0] nib);
        seg_t code;
        case (nib)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low segment decoder with forced blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    input  logic             blank_i,
    output seg_t             seg_c_o
);

    assign seg_c_o = blank_i ? SEG_BLANK : seg_code(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame input snapshot,
// anti-ghosting dead time and an internally generated blink phase.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS         = 4,
    parameter int unsigned SCAN_DIV         = 1000,
    parameter int unsigned DEAD_CYC         = 2,
    parameter int unsigned BLINK_DIV        = 500000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NIB_W*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]       flash_mask_i,
    output logic [SEG_W-1:0]          seg_o,
    output logic [N_DIGITS-1:0]       an_o,
    output logic                      frame_o,
    output logic                      blink_phase_o
);

    localparam int unsigned P_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned B_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{ANODE_ACTIVE_LOW}};

    logic [P_W-1:0]                   p_q, p_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [B_W-1:0]                   blink_q, blink_d;
    logic                             phase_q, phase_d;
    logic [N_DIGITS-1:0][NIB_W-1:0]   snap_dig_q, snap_dig_d;
    logic [N_DIGITS-1:0]              snap_flash_q, snap_flash_d;
    seg_t                             seg_q, seg_d;
    logic [N_DIGITS-1:0]              an_q, an_d;
    logic                             frame_q, frame_d;

    logic                             p_wrap;
    logic                             idx_wrap;
    logic                             slot_act;
    logic [NIB_W-1:0]                 cur_nib;
    logic                             cur_blank;
    logic [N_DIGITS-1:0]              an_onehot;
    seg_t                             dec_seg;

    seg7_decode u_decode (
        .nib_i   (cur_nib),
        .blank_i (cur_blank),
        .seg_c_o (dec_seg)
    );

    // Next-state: scan counters, blink timer, snapshot and registered pin values.
    always_comb begin
        p_d          = p_q;
        idx_d        = idx_q;
        blink_d      = blink_q;
        phase_d      = phase_q;
        snap_dig_d   = snap_dig_q;
        snap_flash_d = snap_flash_q;

        p_wrap   = en && (p_q == P_W'(SCAN_DIV - 1));
        idx_wrap = p_wrap && (idx_q == IDX_W'(N_DIGITS - 1));

        if (!en) begin
            p_d   = '0;
            idx_d = '0;
        end else if (p_wrap) begin
            p_d   = '0;
            idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
        end else begin
            p_d   = p_q + P_W'(1);
        end

        if (blink_q == B_W'(BLINK_DIV - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + B_W'(1);
        end

        // Frame-boundary capture keeps a whole frame consistent; idle tracks live inputs.
        if (!en || idx_wrap) begin
            snap_dig_d   = digits_i;
            snap_flash_d = flash_mask_i;
        end

        slot_act  = en && (p_q >= P_W'(DEAD_CYC));
        cur_nib   = snap_dig_q[idx_q];
        cur_blank = !slot_act || (snap_flash_q[idx_q] && phase_q);
        an_onehot = N_DIGITS'(1) << idx_q;

        seg_d   = dec_seg;
        an_d    = AN_OFF ^ (slot_act ? an_onehot : '0);
        frame_d = idx_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q          <= '0;
            idx_q        <= '0;
            blink_q      <= '0;
            phase_q      <= 1'b0;
            snap_dig_q   <= '0;
            snap_flash_q <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            frame_q      <= 1'b0;
        end else begin
            p_q          <= p_d;
            idx_q        <= idx_d;
            blink_q      <= blink_d;
            phase_q      <= phase_d;
            snap_dig_q   <= snap_dig_d;
            snap_flash_q <= snap_flash_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign seg_o         = seg_q;
    assign an_o          = an_q;
    assign frame_o       = frame_q;
    assign blink_phase_o = phase_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random
// stimulus compared every cycle against a time-based reference model.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 64;
    localparam int FR = ND * SD;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        en     = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  mask   = 4'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;
    logic        phase;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [3:0] exp_an1  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg1 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS         (ND),
        .SCAN_DIV         (SD),
        .DEAD_CYC         (DC),
        .BLINK_DIV        (BD),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .digits_i      (digits),
        .flash_mask_i  (mask),
        .seg_o         (seg),
        .an_o          (an),
        .frame_o       (frame),
        .blink_phase_o (phase)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: t = cycles enabled since en rose, c = cycles since reset.
    int         m_t     = 0;
    int         m_c     = 0;
    logic [15:0] m_snap = 16'h0;
    logic [3:0] m_flash = 4'h0;
    logic [6:0] e_seg   = 7'h7F;
    logic [3:0] e_an    = 4'hF;
    logic       e_frame = 1'b0;
    logic       e_phase = 1'b0;

    function automatic logic [6:0] ref_seg(input int v);
        return (v < 10) ? seg_tbl[v] : 7'h7F;
    endfunction

    function automatic bit lit(input int t, input logic e);
        return e && ((t % SD) >= DC);
    endfunction

    function automatic logic [6:0] disp_seg(input logic [15:0] snap, input logic [3:0] fl,
                                            input int t, input int c);
        int d;
        int nib;
        d   = (t / SD) % ND;
        nib = int'((snap >> (4 * d)) & 16'hF);
        if (fl[d] && (((c / BD) % 2) == 1)) return 7'h7F;
        return ref_seg(nib);
    endfunction

    function automatic logic [3:0] disp_an(input int t);
        logic [3:0] a;
        a = 4'hF;
        a[(t / SD) % ND] = 1'b0;
        return a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_c <= 0; m_snap <= 16'h0; m_flash <= 4'h0;
            e_seg <= 7'h7F; e_an <= 4'hF; e_frame <= 1'b0; e_phase <= 1'b0;
        end else begin
            e_seg   <= lit(m_t, en) ? disp_seg(m_snap, m_flash, m_t, m_c) : 7'h7F;
            e_an    <= lit(m_t, en) ? disp_an(m_t) : 4'hF;
            e_frame <= en && ((m_t % FR) == FR - 1);
            if (!en || ((m_t % FR) == FR - 1)) begin
                m_snap  <= digits;
                m_flash <= mask;
            end
            m_t     <= en ? m_t + 1 : 0;
            m_c     <= m_c + 1;
            e_phase <= (((m_c + 1) / BD) % 2) == 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("model_seg", 32'(seg), 32'(e_seg));
            check_eq("model_an", 32'(an), 32'(e_an));
            check_eq("model_frame", 32'(frame), 32'(e_frame));
            check_eq("model_phase", 32'(phase), 32'(e_phase));
        end
    end

    task automatic wait_an(input logic [3:0] want, input string tag);
        int k = 0;
        while (an !== want && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(an), 32'(want));
    endtask

    task automatic wait_frame(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame !== 1'b1 && k < 100);
        check_eq(tag, 32'(frame), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int frames, act, lit_n, blank_n, other_bad;

        repeat (2) @(negedge clk);
        check_eq("rst_seg", 32'(seg), 32'h7F);
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_frame", 32'(frame), 32'd0);
        check_eq("rst_phase", 32'(phase), 32'd0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // 1: static 1234 scan
        @(negedge clk);
        digits = 16'h1234;
        mask   = 4'h0;
        @(negedge clk);
        en     = 1'b1;
        frames = 0;
        act    = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (frame === 1'b1) frames++;
            if (an !== 4'hF) act++;
            if (i <= 2) check_eq("t1_dead", 32'(an), 32'hF);
            if (i >= 3 && i <= 27 && ((i - 3) % 8) == 0) begin
                check_eq("t1_an", 32'(an), 32'(exp_an1[(i - 3) / 8]));
                check_eq("t1_seg", 32'(seg), 32'(exp_seg1[(i - 3) / 8]));
            end
        end
        check_eq("t1_frames", 32'(frames), 32'd2);
        check_eq("t1_active", 32'(act), 32'd48);

        // 2: mid-frame change stays hidden until next frame
        wait_an(4'b1011, "t2_wait_d2");
        digits = 16'h9876;
        wait_an(4'b0111, "t2_wait_d3");
        check_eq("t2_old_d3", 32'(seg), 32'b1111001);
        wait_frame("t2_frame");
        wait_an(4'b1110, "t2_wait_d0");
        check_eq("t2_new_d0", 32'(seg), 32'b0000010);

        // 3: flashing digit 0
        digits = 16'h0005;
        mask   = 4'b0001;
        wait_frame("t3_frame");
        lit_n = 0; blank_n = 0; other_bad = 0;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (an === 4'b1110 && seg === 7'b0010010) lit_n++;
            if (an === 4'b1110 && seg === 7'h7F) blank_n++;
            if (an !== 4'b1110 && an !== 4'hF && seg !== 7'b1000000) other_bad++;
        end
        check_eq("t3_lit_seen", 32'(lit_n > 0), 32'd1);
        check_eq("t3_blank_seen", 32'(blank_n > 0), 32'd1);
        check_eq("t3_others", 32'(other_bad), 32'd0);

        // 4: non-BCD nibbles blank while anodes keep scanning
        digits = 16'hFABC;
        mask   = 4'h0;
        wait_frame("t4_frame");
        act = 0; lit_n = 0;
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            if (an !== 4'hF) act++;
            if (seg !== 7'h7F) lit_n++;
        end
        check_eq("t4_active", 32'(act), 32'd24);
        check_eq("t4_blank", 32'(lit_n), 32'd0);

        // 5: en drop mid-slot, then restart on digit 0
        digits = 16'h4321;
        wait_an(4'b1101, "t5_wait_d1");
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_eq("t5_off_an", 32'(an), 32'hF);
        check_eq("t5_off_seg", 32'(seg), 32'h7F);
        check_eq("t5_off_frame", 32'(frame), 32'd0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t5_dead", 32'(an), 32'hF);
        @(negedge clk);
        check_eq("t5_d0_an", 32'(an), 32'b1110);
        check_eq("t5_d0_seg", 32'(seg), 32'b1111001);

        // 6: random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 99) == 0) mask = 4'($urandom);
            if (en && $urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
        end
        en = 1'b1;

        // 7: asynchronous reset mid-slot during blink off-phase
        begin
            int k = 0;
            while (!(phase === 1'b1 && an !== 4'hF) && k < 300) begin
                @(negedge clk);
                k++;
            end
            check_eq("t7_setup", 32'(phase === 1'b1 && an !== 4'hF), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_seg", 32'(seg), 32'h7F);
        check_eq("t7_an", 32'(an), 32'hF);
        check_eq("t7_frame", 32'(frame), 32'd0);
        check_eq("t7_phase", 32'(phase), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t7_restart_an", 32'(an), 32'b1110);
        repeat (100) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
